sm_feed_arb: RTL and testbench

- Round-robin scheduler that shares one serial sequence detector (serial bit in, registered match pulse out) between two byte requesters.
- Accepts a byte from the granted requester and shifts it MSB-first into the detector.
- Appends guard bits so that pattern history does not carry from one byte into the next.
- Attributes each match pulse to the requester whose bits produced it and keeps per-requester match counts.

---
 rtl/sm_feed_arb.sv | 163 ++++++++++++++++
 tb/tb_sm_feed_arb.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_feed_arb.sv
// rtl/sm_feed_arb.sv - round-robin feeder sharing one serial sequence detector between two byte requesters
module sm_feed_arb #(
  parameter int unsigned GUARD_BITS = 5,
  parameter logic        FLUSH_VAL  = 1'b0,
  parameter int unsigned DET_LAT    = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  output logic             req1_ready,
  output logic             det_data,
  output logic             det_bit_vld,
  input  logic             det_find,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] match0_cnt,
  output logic [CNT_W-1:0] match1_cnt,
  output logic             busy,
  output logic             done,
  output logic             done_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GUARD = 2'd2
  } state_t;

  localparam logic [3:0]       GUARD_LAST = 4'(GUARD_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [3:0] guard_cnt;
  logic       owner;
  logic       rr_last;   // id of the requester served most recently
  logic       grant0;
  logic       grant1;
  logic       dtag_v;
  logic       dtag_id;

  // Tie goes to the requester not served last; a lone requester always wins.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || rr_last);
    grant1 = req1_valid && !grant0;
  end

  // Ready only exists in IDLE and is forced low while reset is held.
  assign req0_ready = rst_n && (state == IDLE) && grant0;
  assign req1_ready = rst_n && (state == IDLE) && grant1;

  // Main sequencer: accept a byte, shift it MSB-first, then flush with guard bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= 8'h00;
      bit_cnt     <= 3'd0;
      guard_cnt   <= 4'd0;
      owner       <= 1'b0;
      rr_last     <= 1'b1;
      det_data    <= FLUSH_VAL;
      det_bit_vld <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_id     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          det_data    <= FLUSH_VAL;
          det_bit_vld <= 1'b0;
          busy        <= 1'b0;
          if (grant0 || grant1) begin
            shreg       <= grant1 ? req1_data : req0_data;
            det_data    <= grant1 ? req1_data[7] : req0_data[7];
            det_bit_vld <= 1'b1;
            busy        <= 1'b1;
            owner       <= grant1;
            rr_last     <= grant1;
            bit_cnt     <= 3'd0;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt == 3'd7) begin
            det_data    <= FLUSH_VAL;
            det_bit_vld <= 1'b0;
            guard_cnt   <= 4'd0;
            state       <= GUARD;
          end else begin
            // shreg[7] is already on det_data, so the next bit is shreg[6].
            det_data <= shreg[6];
            shreg    <= {shreg[6:0], 1'b0};
            bit_cnt  <= bit_cnt + 3'd1;
          end
        end
        GUARD: begin
          det_data <= FLUSH_VAL;
          if (guard_cnt == GUARD_LAST) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            done_id <= owner;
            state   <= IDLE;
          end else begin
            guard_cnt <= guard_cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The tag rides alongside det_data; busy and owner are registered on the same edges.
  generate
    if (DET_LAT == 0) begin : g_no_lat
      assign dtag_v  = busy;
      assign dtag_id = owner;
    end else begin : g_lat
      logic [DET_LAT-1:0] pipe_v;
      logic [DET_LAT-1:0] pipe_id;

      // Delay the tag by the detector latency so each match finds its owner.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_v  <= '0;
          pipe_id <= '0;
        end else begin
          pipe_v  <= (pipe_v << 1) | DET_LAT'(busy);
          pipe_id <= (pipe_id << 1) | DET_LAT'(owner);
        end
      end

      assign dtag_v  = pipe_v[DET_LAT-1];
      assign dtag_id = pipe_id[DET_LAT-1];
    end
  endgenerate

  // Saturating per-requester match counters; clear wins over a same-cycle match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match0_cnt <= '0;
      match1_cnt <= '0;
    end else if (clr_cnt) begin
      match0_cnt <= '0;
      match1_cnt <= '0;
    end else if (det_find && dtag_v) begin
      if (!dtag_id && (match0_cnt != CNT_MAX)) begin
        match0_cnt <= match0_cnt + CNT_W'(1);
      end
      if (dtag_id && (match1_cnt != CNT_MAX)) begin
        match1_cnt <= match1_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sm_feed_arb.sv
// tb/tb_sm_feed_arb.sv - self-checking bench for sm_feed_arb with a 10110 detector model
module tb_sm_feed_arb;

  localparam int GB = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic [7:0]  req0_data = 8'h00;
  logic        req1_valid = 1'b0;
  logic [7:0]  req1_data = 8'h00;
  logic        clr_cnt = 1'b0;
  logic        find_force = 1'b0;
  logic        det_find;

  logic        req0_ready, req1_ready, det_data, det_bit_vld, busy, done, done_id;
  logic [15:0] match0_cnt, match1_cnt;

  logic        s_req0_ready, s_req1_ready, s_det_data, s_det_bit_vld, s_busy, s_done, s_done_id;
  logic [3:0]  s_match0_cnt, s_match1_cnt;

  sm_feed_arb u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .det_data(det_data), .det_bit_vld(det_bit_vld), .det_find(det_find),
    .clr_cnt(clr_cnt), .match0_cnt(match0_cnt), .match1_cnt(match1_cnt),
    .busy(busy), .done(done), .done_id(done_id)
  );

  // Narrow-counter copy on the same stimulus, used to reach saturation quickly.
  sm_feed_arb #(.CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(s_req1_ready),
    .det_data(s_det_data), .det_bit_vld(s_det_bit_vld), .det_find(det_find),
    .clr_cnt(clr_cnt), .match0_cnt(s_match0_cnt), .match1_cnt(s_match1_cnt),
    .busy(s_busy), .done(s_done), .done_id(s_done_id)
  );

  always #5 clk = ~clk;

  // Detector model: overlapping 10110, registered match one cycle after the last bit.
  logic [3:0] hist;
  logic       find_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist   <= 4'h0;
      find_q <= 1'b0;
    end else begin
      hist   <= {hist[2:0], det_data};
      find_q <= ({hist, det_data} == 5'b10110);
    end
  end
  assign det_find = find_q | find_force;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic b;
    logic v;
    logic id;
  } exp_bit_t;

  exp_bit_t    bq[$];
  logic        glog[$];
  int          hs_count = 0;
  logic        m_last = 1'b1;
  logic        done_pend = 1'b0;
  logic        done_own = 1'b0;
  logic        dtag_v = 1'b0;
  logic        dtag_id = 1'b0;
  int unsigned em0 = 0, em1 = 0, es0 = 0, es1 = 0;
  logic        g0, g1, tag_v, tag_id;
  logic [7:0]  gdata;
  exp_bit_t    e;

  // Scoreboard monitor: predicts grants, pushes the expected bit stream, pops and compares.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_det_data", det_data, 0);
      chk("rst_bit_vld", det_bit_vld, 0);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_done_id", done_id, 0);
      chk("rst_m0", match0_cnt, 0);
      chk("rst_m1", match1_cnt, 0);
      chk("rst_s_m0", s_match0_cnt, 0);
      bq.delete();
      done_pend = 1'b0;
      m_last    = 1'b1;
      dtag_v    = 1'b0;
      dtag_id   = 1'b0;
      em0 = 0; em1 = 0; es0 = 0; es1 = 0;
    end else begin
      chk("done", done, done_pend);
      chk("s_done", s_done, done_pend);
      if (done_pend) begin
        chk("done_id", done_id, done_own);
        chk("s_done_id", s_done_id, done_own);
      end
      done_pend = 1'b0;
      chk("match0_cnt", match0_cnt, em0);
      chk("match1_cnt", match1_cnt, em1);
      chk("s_match0_cnt", s_match0_cnt, es0);
      chk("s_match1_cnt", s_match1_cnt, es1);
      if (bq.size() == 0) begin
        g0 = req0_valid && (!req1_valid || m_last);
        g1 = req1_valid && !g0;
        chk("idle_det_data", det_data, 0);
        chk("idle_bit_vld", det_bit_vld, 0);
        chk("idle_busy", busy, 0);
        chk("s_idle_busy", s_busy, 0);
        tag_v  = 1'b0;
        tag_id = 1'b0;
        if (g0 || g1) begin
          gdata = g1 ? req1_data : req0_data;
          for (int i = 7; i >= 0; i--) bq.push_back('{b: gdata[i], v: 1'b1, id: g1});
          for (int i = 0; i < GB; i++) bq.push_back('{b: 1'b0, v: 1'b0, id: g1});
          m_last = g1;
          hs_count++;
          glog.push_back(g1);
        end
      end else begin
        g0 = 1'b0;
        g1 = 1'b0;
        e = bq.pop_front();
        chk("det_data", det_data, e.b);
        chk("s_det_data", s_det_data, e.b);
        chk("det_bit_vld", det_bit_vld, e.v);
        chk("s_det_bit_vld", s_det_bit_vld, e.v);
        chk("busy", busy, 1);
        chk("s_busy", s_busy, 1);
        tag_v  = 1'b1;
        tag_id = e.id;
        if (bq.size() == 0) begin
          done_pend = 1'b1;
          done_own  = e.id;
        end
      end
      chk("req0_ready", req0_ready, g0);
      chk("req1_ready", req1_ready, g1);
      chk("s_req0_ready", s_req0_ready, g0);
      chk("s_req1_ready", s_req1_ready, g1);
      if (clr_cnt) begin
        em0 = 0; em1 = 0; es0 = 0; es1 = 0;
      end else if (det_find && dtag_v) begin
        if (!dtag_id) begin
          if (em0 < 65535) em0++;
          if (es0 < 15) es0++;
        end else begin
          if (em1 < 65535) em1++;
          if (es1 < 15) es1++;
        end
      end
      dtag_v  = tag_v;
      dtag_id = tag_id;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int target);
    for (int i = 0; i < 2000 && hs_count < target; i++) tick();
    chk("hs_timeout", (hs_count >= target), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (bq.size() != 0 || done_pend); i++) tick();
    chk("idle_timeout", (bq.size() == 0 && !done_pend), 1);
    repeat (3) tick();
  endtask

  task automatic pulse_clr();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
  endtask

  typedef struct {
    bit         v0;
    bit         v1;
    logic [7:0] d0;
    logic [7:0] d1;
    int         n;
    bit         force_find;
    bit         first;
    bit         alt;
    int         m0;
    int         m1;
  } vec_t;

  task automatic run_entry(input vec_t t);
    int base;
    pulse_clr();
    glog.delete();
    base       = hs_count;
    find_force = t.force_find;
    req0_data  = t.d0;
    req1_data  = t.d1;
    req0_valid = t.v0;
    req1_valid = t.v1;
    wait_hs(base + t.n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
    find_force = 1'b0;
    chk("entry_m0", match0_cnt, t.m0);
    chk("entry_m1", match1_cnt, t.m1);
    chk("entry_s_m0", s_match0_cnt, (t.m0 > 15) ? 15 : t.m0);
    chk("entry_s_m1", s_match1_cnt, (t.m1 > 15) ? 15 : t.m1);
    chk("entry_grants", glog.size(), t.n);
    for (int i = 0; i < glog.size() && i < t.n; i++)
      chk("entry_grant_order", glog[i], t.first ^ (t.alt & i[0]));
  endtask

  vec_t tbl[6];

  initial begin
    int base;
    //         v0    v1    d0     d1     n  force first alt m0  m1
    tbl[0] = '{1'b1, 1'b0, 8'hB0, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1, 0};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 8'h16, 1, 1'b0, 1'b1, 1'b0, 0, 1};
    tbl[2] = '{1'b1, 1'b1, 8'h2D, 8'h2D, 4, 1'b0, 1'b0, 1'b1, 2, 2};
    tbl[3] = '{1'b1, 1'b0, 8'hB6, 8'h00, 1, 1'b0, 1'b0, 1'b0, 2, 0};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 8'h5A, 1, 1'b0, 1'b1, 1'b0, 0, 1};
    tbl[5] = '{1'b1, 1'b0, 8'h00, 8'h00, 2, 1'b1, 1'b0, 1'b0, 26, 0};

    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("quiet_det_data", det_data, 0);
    chk("quiet_ready0", req0_ready, 0);
    chk("quiet_ready1", req1_ready, 0);
    chk("quiet_busy", busy, 0);
    chk("quiet_m0", match0_cnt, 0);
    chk("quiet_m1", match1_cnt, 0);

    for (int k = 0; k < 6; k++) run_entry(tbl[k]);

    // Reset in the middle of shifting a byte: no done, counters cleared, fresh start.
    pulse_clr();
    base       = hs_count;
    req0_data  = 8'hB0;
    req0_valid = 1'b1;
    wait_hs(base + 1);
    req0_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_bit_vld", det_bit_vld, 0);
    chk("midrst_done", done, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("postrst_busy", busy, 0);
    chk("postrst_done", done, 0);
    chk("postrst_m0", match0_cnt, 0);
    run_entry(tbl[0]);

    // Clear in the same cycle as a credited match.
    pulse_clr();
    base       = hs_count;
    find_force = 1'b1;
    req1_data  = 8'h00;
    req1_valid = 1'b1;
    wait_hs(base + 1);
    req1_valid = 1'b0;
    repeat (5) tick();
    chk("preclr_m1_nonzero", (match1_cnt != 0), 1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_priority_m1", match1_cnt, 0);
    chk("clr_priority_s_m1", s_match1_cnt, 0);
    wait_idle();
    find_force = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
